// File: rtl/trace_capture.sv
// trace_capture: samples CPU observation signals into a circular FIFO
// and streams each stored entry out as three 32-bit beats.
module trace_capture #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              cap_en,
    input  logic [31:0]       pc,
    input  logic [31:0]       inst,
    input  logic [31:0]       alu_r,
    input  logic              dm_r,
    input  logic              dm_w,
    input  logic              arm,
    input  logic              stop,
    input  logic              trig_en,
    input  logic [31:0]       trig_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [1:0]        out_beat,
    output logic              out_last,
    output logic [1:0]        out_flags,
    output logic [1:0]        state,
    output logic [ADDR_W:0]   count,
    output logic [15:0]       drop_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [15:0]       DROP_MAX = 16'hFFFF;

    state_t cur_st;
    state_t nxt_st;

    // Entry layout: {dm_w, dm_r, alu_r, inst, pc}
    logic [97:0]       mem [DEPTH];
    logic [97:0]       head;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [1:0]        beat;

    logic trig_hit;
    logic full;
    logic xfer;
    logic pop;
    logic push;
    logic drop;

    assign trig_hit  = !trig_en || (pc == trig_pc);
    assign full      = (count == CNT_FULL);
    assign out_valid = (count != '0);
    assign xfer      = out_valid && out_ready;
    assign pop       = xfer && (beat == 2'd2);
    assign head      = mem[rd_ptr];
    assign state     = cur_st;

    // State register
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            cur_st <= ST_IDLE;
        end else begin
            cur_st <= nxt_st;
        end
    end

    // Next state: arm beats stop, stop beats a trigger hit
    always_comb begin
        nxt_st = cur_st;
        if (arm) begin
            nxt_st = ST_ARMED;
        end else if (stop) begin
            nxt_st = ST_IDLE;
        end else begin
            unique case (cur_st)
                ST_IDLE:    nxt_st = ST_IDLE;
                ST_ARMED:   if (cap_en && trig_hit) nxt_st = ST_CAPTURE;
                ST_CAPTURE: nxt_st = ST_CAPTURE;
                default:    nxt_st = ST_IDLE;
            endcase
        end
    end

    // Decide whether this cycle's sample is stored, dropped or ignored;
    // a full FIFO still accepts when the head is popping this cycle
    always_comb begin
        push = 1'b0;
        drop = 1'b0;
        if (cap_en && !arm) begin
            unique case (cur_st)
                ST_ARMED: begin
                    push = trig_hit && !stop;
                end
                ST_CAPTURE: begin
                    if (!full || pop) begin
                        push = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end
                default: begin
                    push = 1'b0;
                end
            endcase
        end
    end

    // Sample storage; contents need no reset since reads are gated by count
    always_ff @(posedge clk_in) begin
        if (push) begin
            mem[wr_ptr] <= {dm_w, dm_r, alu_r, inst, pc};
        end
    end

    // Read/write pointers wrap naturally at ADDR_W bits
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (arm) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Occupancy; simultaneous push and pop leaves it unchanged
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (arm) begin
            count <= '0;
        end else begin
            unique case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Beat index within the head entry
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            beat <= 2'd0;
        end else if (arm) begin
            beat <= 2'd0;
        end else if (xfer) begin
            beat <= (beat == 2'd2) ? 2'd0 : beat + 2'd1;
        end
    end

    // Saturating count of samples rejected by a full FIFO
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            drop_cnt <= '0;
        end else if (arm) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != DROP_MAX)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

    // Beat mux; everything reads as zero while nothing is presented
    always_comb begin
        out_data  = '0;
        out_beat  = '0;
        out_last  = 1'b0;
        out_flags = '0;
        if (out_valid) begin
            out_beat  = beat;
            out_last  = (beat == 2'd2);
            out_flags = head[97:96];
            unique case (beat)
                2'd0:    out_data = head[31:0];
                2'd1:    out_data = head[63:32];
                2'd2:    out_data = head[95:64];
                default: out_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_trace_capture.sv
// tb_trace_capture: directed checks of capture, trigger, overflow,
// wrap/backpressure, arm-during-readout and asynchronous reset.
module tb_trace_capture;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        cap_en;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] alu_r;
    logic        dm_r;
    logic        dm_w;
    logic        arm;
    logic        stop;
    logic        trig_en;
    logic [31:0] trig_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_beat;
    logic        out_last;
    logic [1:0]  out_flags;
    logic [1:0]  state;
    logic [4:0]  count;
    logic [15:0] drop_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk_in = ~clk_in;

    trace_capture #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .cap_en    (cap_en),
        .pc        (pc),
        .inst      (inst),
        .alu_r     (alu_r),
        .dm_r      (dm_r),
        .dm_w      (dm_w),
        .arm       (arm),
        .stop      (stop),
        .trig_en   (trig_en),
        .trig_pc   (trig_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_beat  (out_beat),
        .out_last  (out_last),
        .out_flags (out_flags),
        .state     (state),
        .count     (count),
        .drop_cnt  (drop_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic [31:0] f_inst(input logic [31:0] p);
        return {16'hC0DE, p[15:0]};
    endfunction

    function automatic logic [31:0] f_alu(input logic [31:0] p);
        return p + 32'h1000;
    endfunction

    function automatic logic [31:0] f_beat(input logic [31:0] p,
                                           input int b);
        if (b == 0) return p;
        if (b == 1) return f_inst(p);
        return f_alu(p);
    endfunction

    task automatic drive(input logic [31:0] p);
        cap_en = 1'b1;
        pc     = p;
        inst   = f_inst(p);
        alu_r  = f_alu(p);
        dm_r   = p[2];
        dm_w   = p[3];
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic read_entry(input logic [31:0] p, input string tag);
        out_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            chk({tag, ".valid"}, out_valid, 1);
            chk({tag, ".beat"},  out_beat, b);
            chk({tag, ".data"},  out_data, f_beat(p, b));
            chk({tag, ".last"},  out_last, (b == 2));
            chk({tag, ".flags"}, out_flags, p[3:2]);
            tick();
        end
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] q[$];
        int sent;
        int got;
        int bexp;
        int t;

        reset = 1'b0; cap_en = 0; pc = 0; inst = 0; alu_r = 0;
        dm_r = 0; dm_w = 0; arm = 0; stop = 0; trig_en = 0;
        trig_pc = 0; out_ready = 0;
        #1;
        chk("rst.state", state, 0);
        chk("rst.count", count, 0);
        chk("rst.valid", out_valid, 0);
        chk("rst.drop",  drop_cnt, 0);
        chk("rst.data",  out_data, 0);
        #11 reset = 1'b1;
        tick();

        // Free-run capture of five samples
        pulse_arm();
        chk("free.armed", state, 1);
        for (int i = 0; i < 5; i++) begin
            drive(32'(i * 4));
            tick();
            chk("free.state", state, 2);
        end
        cap_en = 0;
        chk("free.count", count, 5);
        for (int i = 0; i < 5; i++) read_entry(32'(i * 4), "free");
        chk("free.empty", count, 0);
        chk("free.novalid", out_valid, 0);
        chk("free.drop", drop_cnt, 0);
        pulse_stop();
        chk("free.idle", state, 0);

        // PC trigger at 0x20
        trig_en = 1'b1;
        trig_pc = 32'h20;
        pulse_arm();
        for (int i = 0; i < 16; i++) begin
            drive(32'(i * 4));
            tick();
            chk("trig.state", state, (i * 4 >= 32'h20) ? 2 : 1);
        end
        cap_en = 0;
        chk("trig.count", count, 8);
        for (int i = 0; i < 8; i++) read_entry(32'h20 + 32'(i * 4), "trig");
        pulse_stop();
        trig_en = 1'b0;

        // Overflow: 20 samples into 16 entries, then pop+push when full
        pulse_arm();
        for (int i = 0; i < 20; i++) begin
            drive(32'h100 + 32'(i * 4));
            tick();
        end
        cap_en = 0;
        chk("ovf.count", count, 16);
        chk("ovf.drop", drop_cnt, 4);
        out_ready = 1'b1;
        tick();
        tick();
        chk("ovf.last", out_last, 1);
        drive(32'h200);
        tick();
        cap_en = 0;
        out_ready = 1'b0;
        chk("ovf.pp_count", count, 16);
        chk("ovf.pp_drop", drop_cnt, 4);
        for (int i = 1; i < 16; i++) read_entry(32'h100 + 32'(i * 4), "ovf");
        read_entry(32'h200, "ovf.tail");
        chk("ovf.empty", count, 0);
        pulse_stop();

        // Wrap with 1-on/2-off backpressure against a reference queue
        pulse_arm();
        chk("wrap.drop_clr", drop_cnt, 0);
        sent = 0; got = 0; bexp = 0; t = 0;
        while ((sent < 40 || q.size() != 0) && t < 3000) begin
            out_ready = (t % 3 == 0);
            if (t % 8 == 0 && sent < 40) begin
                drive(32'h400 + 32'(sent * 4));
                q.push_back(32'h400 + 32'(sent * 4));
                sent++;
            end else begin
                cap_en = 1'b0;
            end
            if (out_valid && out_ready && q.size() > 0) begin
                chk("wrap.data", out_data, f_beat(q[0], bexp));
                chk("wrap.beat", out_beat, bexp);
                if (bexp == 2) begin
                    void'(q.pop_front());
                    got++;
                    bexp = 0;
                end else begin
                    bexp++;
                end
            end
            tick();
            t++;
        end
        cap_en = 0;
        out_ready = 0;
        chk("wrap.read", got, 40);
        chk("wrap.count", count, 0);
        chk("wrap.drop", drop_cnt, 0);
        pulse_stop();

        // Arm while stalled mid-entry
        pulse_arm();
        for (int i = 0; i < 3; i++) begin
            drive(32'h500 + 32'(i * 4));
            tick();
        end
        cap_en = 0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("marm.beat1", out_beat, 1);
        chk("marm.data1", out_data, f_inst(32'h500));
        pulse_arm();
        chk("marm.valid", out_valid, 0);
        chk("marm.count", count, 0);
        chk("marm.state", state, 1);
        chk("marm.drop", drop_cnt, 0);
        chk("marm.odata", out_data, 0);
        drive(32'h600);
        tick();
        cap_en = 0;
        chk("marm.newbeat", out_beat, 0);
        chk("marm.newdata", out_data, 32'h600);
        pulse_stop();

        // Asynchronous reset mid-capture
        pulse_arm();
        for (int i = 0; i < 7; i++) begin
            drive(32'h700 + 32'(i * 4));
            tick();
        end
        cap_en = 0;
        chk("arst.pre_count", count, 7);
        chk("arst.pre_state", state, 2);
        #2 reset = 1'b0;
        #1;
        chk("arst.state", state, 0);
        chk("arst.count", count, 0);
        chk("arst.valid", out_valid, 0);
        chk("arst.data", out_data, 0);
        chk("arst.flags", out_flags, 0);
        #3 reset = 1'b1;
        tick();
        chk("arst.idle", state, 0);
        chk("arst.post_count", count, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
